// File: rtl/fifo_rd_pkg.sv
// Shared types and constants for the read-side FIFO controller.
package fifo_rd_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BURST = 2'd1,
      FLUSH = 2'd2
   } rd_state_e;

   localparam int RD_COUNT_W = 16;

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry head/tail skid buffer that absorbs the FIFO's one-cycle read latency.
module fifo_rd_skid #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk_read,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_last,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_last,
   output logic [1:0]            occupancy
);

   logic [DATA_WIDTH-1:0] head_data_q, head_data_d;
   logic [DATA_WIDTH-1:0] tail_data_q, tail_data_d;
   logic                  head_last_q, head_last_d;
   logic                  tail_last_q, tail_last_d;
   logic [1:0]            occ_q, occ_d;
   logic                  deq;

   assign out_valid = (occ_q != 2'd0);
   assign out_data  = head_data_q;
   assign out_last  = head_last_q;
   assign occupancy = occ_q;
   assign deq       = out_valid && out_ready;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      head_data_d = head_data_q;
      head_last_d = head_last_q;
      tail_data_d = tail_data_q;
      tail_last_d = tail_last_q;
      occ_d       = occ_q;
      if (deq) begin
         head_data_d = tail_data_q;
         head_last_d = tail_last_q;
         occ_d       = occ_q - 2'd1;
      end
      // The incoming word lands behind whatever survives this cycle's dequeue.
      if (in_valid) begin
         if (occ_d == 2'd0) begin
            head_data_d = in_data;
            head_last_d = in_last;
         end else begin
            tail_data_d = in_data;
            tail_last_d = in_last;
         end
         occ_d = occ_d + 2'd1;
      end
   end

   always_ff @(posedge clk_read) begin
      // NOTE: the data registers are reset too, so m_data reads 0 out of reset rather than X.
      if (rst) begin
         head_data_q <= '0;
         head_last_q <= 1'b0;
         tail_data_q <= '0;
         tail_last_q <= 1'b0;
         occ_q       <= 2'd0;
      end else begin
         head_data_q <= head_data_d;
         head_last_q <= head_last_d;
         tail_data_q <= tail_data_d;
         tail_last_q <= tail_last_d;
         occ_q       <= occ_d;
      end
   end

   skid_no_overflow: assert property (@(posedge clk_read) disable iff (rst)
      !(in_valid && (occ_q == 2'd2) && !deq));

endmodule

// File: rtl/fifo_read_ctrl.sv
// Read-domain FIFO drain: burst reads when enough data is present, timed flush of
// stragglers, credit-limited so the skid buffer can never overflow.
module fifo_read_ctrl
   import fifo_rd_pkg::*;
#(
   parameter int DATA_WIDTH    = 8,
   parameter int BURST_LEN     = 4,
   parameter int FLUSH_TIMEOUT = 16
) (
   input  logic                  clk_read,
   input  logic                  rst,
   input  logic                  fifo_empty,
   input  logic                  fifo_almost_empty,
   input  logic [DATA_WIDTH-1:0] fifo_data_out,
   output logic                  fifo_read_enable,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic                  m_last,
   output logic                  busy,
   output logic [RD_COUNT_W-1:0] rd_count
);

   rd_state_e             state_q, state_d;
   logic [7:0]            burst_cnt_q, burst_cnt_d;
   logic [15:0]           tmo_cnt_q, tmo_cnt_d;
   logic                  inflight_q, inflight_last_q;
   logic [RD_COUNT_W-1:0] rd_count_q;
   logic [1:0]            occ;
   logic [2:0]            used;
   logic                  handshake, credit_ok, read_last;

   assign handshake = m_valid && m_ready;
   // A word leaving the skid this cycle frees its slot for a read issued this cycle.
   assign used      = {1'b0, occ} + {2'b00, inflight_q};
   assign credit_ok = used < (3'd2 + {2'b00, handshake});

   assign fifo_read_enable = !rst && (state_q != IDLE) && !fifo_empty && credit_ok;
   assign read_last        = (state_q == BURST) && (burst_cnt_q == 8'(BURST_LEN - 1));

   always_comb begin
      state_d     = state_q;
      burst_cnt_d = burst_cnt_q;
      tmo_cnt_d   = tmo_cnt_q;
      case (state_q)
         IDLE: begin
            if (!fifo_almost_empty) begin
               state_d     = BURST;
               burst_cnt_d = '0;
               tmo_cnt_d   = '0;
            end else if (fifo_empty) begin
               tmo_cnt_d = '0;
            end else if (tmo_cnt_q == 16'(FLUSH_TIMEOUT - 1)) begin
               state_d   = FLUSH;
               tmo_cnt_d = '0;
            end else begin
               tmo_cnt_d = tmo_cnt_q + 16'd1;
            end
         end
         BURST: begin
            if (fifo_read_enable) begin
               burst_cnt_d = burst_cnt_q + 8'd1;
               if (read_last) state_d = IDLE;
            end
         end
         FLUSH: begin
            if (fifo_empty) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_read) begin
      if (rst) begin
         state_q         <= IDLE;
         burst_cnt_q     <= '0;
         tmo_cnt_q       <= '0;
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
         rd_count_q      <= '0;
      end else begin
         state_q         <= state_d;
         burst_cnt_q     <= burst_cnt_d;
         tmo_cnt_q       <= tmo_cnt_d;
         inflight_q      <= fifo_read_enable;
         inflight_last_q <= fifo_read_enable && read_last;
         if (handshake) rd_count_q <= rd_count_q + 1'b1;
      end
   end

   fifo_rd_skid #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_skid (
      .clk_read (clk_read),
      .rst      (rst),
      .in_valid (inflight_q),
      .in_data  (fifo_data_out),
      .in_last  (inflight_last_q),
      .out_valid(m_valid),
      .out_ready(m_ready),
      .out_data (m_data),
      .out_last (m_last),
      .occupancy(occ)
   );

   assign busy     = (state_q != IDLE) || (occ != 2'd0) || inflight_q;
   assign rd_count = rd_count_q;

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Bench for fifo_read_ctrl: a behavioural FIFO feeds the DUT and a scoreboard
// of expected {data,last} words is checked at every stream handshake.
module tb_fifo_read_ctrl;

   localparam int DATA_WIDTH    = 8;
   localparam int BURST_LEN     = 4;
   localparam int FLUSH_TIMEOUT = 16;

   typedef struct packed {
      logic [7:0] data;
      logic       last;
   } exp_t;

   logic        clk_read = 1'b0;
   logic        rst = 1'b1;
   logic        fifo_empty = 1'b1;
   logic        fifo_almost_empty = 1'b1;
   logic [7:0]  fifo_data_out = '0;
   logic        fifo_read_enable;
   logic [7:0]  m_data;
   logic        m_valid;
   logic        m_ready = 1'b0;
   logic        m_last;
   logic        busy;
   logic [15:0] rd_count;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   rd_en_cnt = 0;
   int   first_rd_cyc = -1;
   int   hs_cnt = 0;
   int   hs_cyc[$];
   logic [7:0] mem[$];
   exp_t exp_q[$];

   fifo_read_ctrl #(
      .DATA_WIDTH   (DATA_WIDTH),
      .BURST_LEN    (BURST_LEN),
      .FLUSH_TIMEOUT(FLUSH_TIMEOUT)
   ) dut (
      .clk_read         (clk_read),
      .rst              (rst),
      .fifo_empty       (fifo_empty),
      .fifo_almost_empty(fifo_almost_empty),
      .fifo_data_out    (fifo_data_out),
      .fifo_read_enable (fifo_read_enable),
      .m_data           (m_data),
      .m_valid          (m_valid),
      .m_ready          (m_ready),
      .m_last           (m_last),
      .busy             (busy),
      .rd_count         (rd_count)
   );

   always #5 clk_read = ~clk_read;

   // FIFO model and scoreboard: flags settle at negedge+1, DUT outputs sampled at
   // negedge+2, and a sampled read pops the model one step after the next posedge.
   always begin : fifo_model
      logic rd_en_s;
      exp_t e;
      @(negedge clk_read);
      #1;
      fifo_empty        = (mem.size() == 0);
      fifo_almost_empty = (mem.size() < BURST_LEN);
      #1;
      rd_en_s = fifo_read_enable;
      if (rd_en_s === 1'b1) begin
         rd_en_cnt++;
         if (first_rd_cyc < 0) first_rd_cyc = cyc;
         checks++;
         if (fifo_empty) begin
            errors++;
            $display("FAIL read_while_empty: read_enable=1 with fifo_empty=%0b at cycle %0d, expected no read", fifo_empty, cyc);
         end
      end
      if (rst) begin
         checks++;
         if (fifo_read_enable !== 1'b0) begin
            errors++;
            $display("FAIL read_during_rst: read_enable=%0b, expected 0", fifo_read_enable);
         end
      end else if (m_valid === 1'b1 && m_ready === 1'b1) begin
         hs_cnt++;
         hs_cyc.push_back(cyc);
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL stream_word: got data=%0h last=%0b, expected no word", m_data, m_last);
         end else begin
            e = exp_q.pop_front();
            if ({m_data, m_last} !== {e.data, e.last}) begin
               errors++;
               $display("FAIL stream_word: got data=%0h last=%0b, expected data=%0h last=%0b",
                        m_data, m_last, e.data, e.last);
            end
         end
      end
      cyc++;
      @(posedge clk_read);
      #1;
      if (rd_en_s === 1'b1) fifo_data_out = (mem.size() != 0) ? mem.pop_front() : 8'hEE;
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic push_word(input logic [7:0] d, input logic last);
      exp_t e;
      e.data = d;
      e.last = last;
      mem.push_back(d);
      exp_q.push_back(e);
   endtask

   task automatic wait_drain(input int budget, input string name);
      bit done = 1'b0;
      for (int k = 0; k < budget; k++) begin
         @(negedge clk_read);
         #3;
         if (exp_q.size() == 0) begin
            done = 1'b1;
            break;
         end
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL %s_drain: %0d words still outstanding, expected 0", name, exp_q.size());
      end
      @(negedge clk_read);
      #3;
   endtask

   task automatic test_reset();
      @(posedge clk_read);
      for (int k = 0; k < 10; k++) begin
         @(negedge clk_read);
         #3;
         checks++;
         if ({fifo_read_enable, m_valid, m_data, m_last, busy, rd_count} !== 29'd0) begin
            errors++;
            $display("FAIL reset_outputs: cycle %0d rd_en=%0b valid=%0b data=%0h last=%0b busy=%0b count=%0h, expected all 0",
                     k, fifo_read_enable, m_valid, m_data, m_last, busy, rd_count);
         end
      end
      @(negedge clk_read);
      rst = 1'b0;
      repeat (3) @(negedge clk_read);
      #3;
      checks++;
      if ({busy, m_valid, rd_en_cnt} !== {1'b0, 1'b0, 32'd0}) begin
         errors++;
         $display("FAIL idle_after_reset: busy=%0b valid=%0b reads=%0d, expected 0 0 0", busy, m_valid, rd_en_cnt);
      end
   endtask

   task automatic test_burst();
      @(negedge clk_read);
      m_ready   = 1'b1;
      rd_en_cnt = 0;
      hs_cyc.delete();
      for (int i = 0; i < 4; i++) push_word(8'(i), i == 3);
      wait_drain(30, "burst");
      checks++;
      if (rd_count !== 16'd4) begin
         errors++;
         $display("FAIL burst_count: rd_count=%0d, expected 4", rd_count);
      end
      checks++;
      if (hs_cyc.size() != 4) begin
         errors++;
         $display("FAIL burst_throughput: %0d handshakes, expected 4", hs_cyc.size());
      end else if (hs_cyc[3] - hs_cyc[0] != 3) begin
         errors++;
         $display("FAIL burst_throughput: span %0d cycles, expected 3", hs_cyc[3] - hs_cyc[0]);
      end
      checks++;
      if (rd_en_cnt != 4) begin
         errors++;
         $display("FAIL burst_reads: %0d reads, expected 4", rd_en_cnt);
      end
      repeat (2) @(negedge clk_read);
      #3;
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL burst_idle: busy=%0b, expected 0", busy);
      end
   endtask

   task automatic test_backpressure();
      @(negedge clk_read);
      m_ready   = 1'b0;
      rd_en_cnt = 0;
      for (int i = 0; i < 4; i++) push_word(8'(i), i == 3);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk_read);
         #3;
         if (m_valid === 1'b1) begin
            checks++;
            if ({m_data, m_last} !== 9'h000) begin
               errors++;
               $display("FAIL bp_hold: data=%0h last=%0b, expected data=0 last=0", m_data, m_last);
            end
         end
      end
      checks++;
      if (rd_en_cnt != 2) begin
         errors++;
         $display("FAIL bp_reads: %0d reads under backpressure, expected 2", rd_en_cnt);
      end
      checks++;
      if ({m_valid, m_data} !== 9'h100) begin
         errors++;
         $display("FAIL bp_head: valid=%0b data=%0h, expected valid=1 data=0", m_valid, m_data);
      end
      @(negedge clk_read);
      m_ready = 1'b1;
      wait_drain(30, "bp");
      checks++;
      if ({rd_en_cnt, rd_count} !== {32'd4, 16'd8}) begin
         errors++;
         $display("FAIL bp_release: reads=%0d rd_count=%0d, expected 4 and 8", rd_en_cnt, rd_count);
      end
   endtask

   task automatic test_flush();
      int start;
      @(negedge clk_read);
      m_ready      = 1'b1;
      rd_en_cnt    = 0;
      first_rd_cyc = -1;
      start        = cyc;
      for (int i = 0; i < 3; i++) push_word(8'hA0 + 8'(i), 1'b0);
      repeat (25) @(negedge clk_read);
      #3;
      checks++;
      if (first_rd_cyc - start != FLUSH_TIMEOUT) begin
         errors++;
         $display("FAIL flush_delay: first read %0d cycles after data, expected %0d", first_rd_cyc - start, FLUSH_TIMEOUT);
      end
      checks++;
      if (rd_en_cnt != 3) begin
         errors++;
         $display("FAIL flush_reads: %0d reads, expected 3", rd_en_cnt);
      end
      checks++;
      if ({busy, rd_count} !== {1'b0, 16'd11} || exp_q.size() != 0) begin
         errors++;
         $display("FAIL flush_end: busy=%0b rd_count=%0d pending=%0d, expected 0 11 0", busy, rd_count, exp_q.size());
      end
   endtask

   task automatic test_mid_reset();
      int  hs0;
      bit  seen = 1'b0;
      @(negedge clk_read);
      m_ready = 1'b1;
      hs0     = hs_cnt;
      for (int i = 0; i < 4; i++) push_word(8'h20 + 8'(i), i == 3);
      for (int k = 0; k < 20; k++) begin
         @(negedge clk_read);
         #3;
         if (hs_cnt >= hs0 + 2) begin
            seen = 1'b1;
            break;
         end
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL mid_rst_wait: %0d handshakes, expected 2", hs_cnt - hs0);
      end
      @(negedge clk_read);
      rst = 1'b1;
      @(negedge clk_read);
      rst = 1'b0;
      mem.delete();
      exp_q.delete();
      #3;
      checks++;
      if ({m_valid, busy, rd_count} !== 18'd0) begin
         errors++;
         $display("FAIL mid_rst_state: valid=%0b busy=%0b rd_count=%0d, expected 0 0 0", m_valid, busy, rd_count);
      end
      hs0       = hs_cnt;
      rd_en_cnt = 0;
      repeat (5) @(negedge clk_read);
      #3;
      checks++;
      if (hs_cnt != hs0 || rd_en_cnt != 0 || m_valid !== 1'b0) begin
         errors++;
         $display("FAIL mid_rst_quiet: handshakes=%0d reads=%0d valid=%0b, expected 0 0 0", hs_cnt - hs0, rd_en_cnt, m_valid);
      end
   endtask

   task automatic test_counter_wrap();
      localparam int N = 65535;
      int pushed = 0;
      bit done   = 1'b0;
      m_ready = 1'b1;
      for (int k = 0; k < 70000; k++) begin
         @(negedge clk_read);
         if (pushed < N && mem.size() < 3) begin
            push_word(8'(pushed), 1'b0);
            pushed++;
         end
         #3;
         if (pushed == N && exp_q.size() == 0) begin
            done = 1'b1;
            break;
         end
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL wrap_stream: pushed=%0d pending=%0d, expected %0d and 0", pushed, exp_q.size(), N);
      end
      @(negedge clk_read);
      #3;
      checks++;
      if (rd_count !== 16'hFFFF) begin
         errors++;
         $display("FAIL wrap_preload: rd_count=%0h, expected ffff", rd_count);
      end
      @(negedge clk_read);
      push_word(8'h5A, 1'b0);
      repeat (25) @(negedge clk_read);
      #3;
      checks++;
      if (rd_count !== 16'h0000 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL wrap_rollover: rd_count=%0h pending=%0d, expected 0000 and 0", rd_count, exp_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_burst();
      test_backpressure();
      test_flush();
      test_mid_reset();
      test_counter_wrap();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
